uparc_rf_wr_arbiter: RTL

Register-file write-port arbiter between the writeback stage and an auxiliary long-latency result source (multiply/divide unit, coprocessor returns). Sits between the writeback stage outputs and the register file's single write port. Buffers auxiliary results in a 2-entry FIFO and gives the pipeline priority. It forces a one-cycle core stall when an auxiliary result has waited too long, and exports a pending-register mask so the control unit can interlock on outstanding auxiliary writes.

---
 rtl/uparc_rf_wr_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uparc_rf_wr_arbiter.sv
// rtl/uparc_rf_wr_arbiter.sv - register-file write-port arbiter between writeback and an auxiliary result source
// Auxiliary results wait in a 2-entry FIFO; writeback wins unless the FIFO head has starved into FORCE.
module uparc_rf_wr_arbiter #(
   parameter int REGNO_W    = 5,
   parameter int REG_W      = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [REGNO_W-1:0]      i_wb_rd_no,
   input  logic [REG_W-1:0]        i_wb_rd_val,
   input  logic                    i_aux_valid,
   input  logic [REGNO_W-1:0]      i_aux_rd_no,
   input  logic [REG_W-1:0]        i_aux_rd_val,
   output logic                    o_aux_ready,
   output logic                    o_rf_wr_en,
   output logic [REGNO_W-1:0]      o_rf_rd_no,
   output logic [REG_W-1:0]        o_rf_rd_val,
   output logic                    o_wb_stall,
   output logic [(1<<REGNO_W)-1:0] o_pend_mask
);

   localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

   typedef enum logic {ARB, FORCE} state_t;

   state_t               state, state_nxt;
   logic [3:0]           starve_cnt, starve_cnt_nxt;
   logic [REGNO_W-1:0]   fifo_no  [2];
   logic [REG_W-1:0]     fifo_val [2];
   logic                 rd_ptr, wr_ptr;
   logic [1:0]           count;
   logic [1:0]           ent_vld;
   logic                 accept, push, pop;
   logic                 grant_wb, grant_head;

   always_comb begin
      o_aux_ready = (count != 2'd2);
      accept      = i_aux_valid && o_aux_ready;
      push        = accept && (i_aux_rd_no != '0);
   end

   // Grant and starvation tracking; the writeback grant is gated by nrst so reset quiets the port.
   always_comb begin
      state_nxt      = state;
      starve_cnt_nxt = starve_cnt;
      grant_wb       = 1'b0;
      grant_head     = 1'b0;
      o_wb_stall     = 1'b0;
      case (state)
         ARB: begin
            if (nrst && (i_wb_rd_no != '0))
               grant_wb = 1'b1;
            else if (count != 2'd0)
               grant_head = 1'b1;
            if ((count != 2'd0) && !grant_head) begin
               if (starve_cnt == STARVE_LAST) begin
                  state_nxt      = FORCE;
                  starve_cnt_nxt = 4'd0;
               end else begin
                  starve_cnt_nxt = starve_cnt + 4'd1;
               end
            end else begin
               starve_cnt_nxt = 4'd0;
            end
         end
         FORCE: begin
            o_wb_stall     = 1'b1;
            grant_head     = (count != 2'd0);
            state_nxt      = ARB;
            starve_cnt_nxt = 4'd0;
         end
         default: begin
            state_nxt      = ARB;
            starve_cnt_nxt = 4'd0;
         end
      endcase
   end

   assign pop = grant_head;

   always_comb begin
      o_rf_wr_en  = grant_wb | grant_head;
      o_rf_rd_no  = '0;
      o_rf_rd_val = '0;
      if (grant_wb) begin
         o_rf_rd_no  = i_wb_rd_no;
         o_rf_rd_val = i_wb_rd_val;
      end else if (grant_head) begin
         o_rf_rd_no  = fifo_no[rd_ptr];
         o_rf_rd_val = fifo_val[rd_ptr];
      end
   end

   always_comb begin
      case (count)
         2'd1:    ent_vld = rd_ptr ? 2'b10 : 2'b01;
         2'd2:    ent_vld = 2'b11;
         default: ent_vld = 2'b00;
      endcase
      o_pend_mask = '0;
      for (int i = 0; i < 2; i++)
         if (ent_vld[i])
            o_pend_mask[fifo_no[i]] = 1'b1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= ARB;
         starve_cnt <= 4'd0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         count      <= 2'd0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
         if (push)
            wr_ptr <= ~wr_ptr;
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Entry payload needs no reset: a zero count already marks every slot empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_no[wr_ptr]  <= i_aux_rd_no;
         fifo_val[wr_ptr] <= i_aux_rd_val;
      end
   end

endmodule
